pipe_stage_skid: RTL and testbench

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

---
 rtl/pipe_stage_skid_pkg.sv | 33 +++
 rtl/pipe_stage_skid_if.sv | 34 +++
 rtl/pipe_stage_skid_entry_reg.sv | 31 +++
 rtl/pipe_stage_skid.sv | 116 +++++++++++
 tb/tb_pipe_stage_skid.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline package: control-bundle field layout, NOP encoding, width
// helper and the per-cycle stage control struct used by the skid stage.
package pipe_stage_skid_pkg;

    // Control bundle carried alongside each pipeline entry (24 bits).
    typedef struct packed {
        logic [7:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       we;
    } ctrl_t;

    localparam int unsigned CTRL_BUNDLE_W = $bits(ctrl_t);

    // Bubble encoding: no register write, opcode 0.
    localparam ctrl_t CTRL_NOP = '0;

    // Per-cycle update decisions for the two entry registers.
    typedef struct packed {
        logic main_valid;
        logic main_load;
        logic main_from_skid;
        logic skid_valid;
        logic skid_load;
    } stage_ctrl_t;

    // Storage width for a field that may be configured to zero bits.
    function automatic int unsigned nz_w(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one skid pipeline stage.
//   master : upstream producer / downstream consumer side (drives in_*, out_ready, flush)
//   slave  : the stage itself (drives in_ready, out_*, err)
// Zero-width payloads are carried as a single unused bit.
interface pipe_stage_skid_if
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CTRL_W = 24
);
    localparam int unsigned DATA_SW = nz_w(DATA_W);
    localparam int unsigned CTRL_SW = nz_w(CTRL_W);

    logic               in_valid;
    logic               in_ready;
    logic [CTRL_SW-1:0] in_ctrl;
    logic [DATA_SW-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [CTRL_SW-1:0] out_ctrl;
    logic [DATA_SW-1:0] out_data;
    logic               flush;
    logic               err;

    modport master (
        output in_valid, in_ctrl, in_data, out_ready, flush,
        input  in_ready, out_valid, out_ctrl, out_data, err
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready, flush,
        output in_ready, out_valid, out_ctrl, out_data, err
    );
endinterface

// File: rtl/pipe_stage_skid_entry_reg.sv
// pipe_entry_reg: one pipeline entry (valid bit + payload).
//   clk, rst      : clock, async active-high reset (clears valid and payload)
//   valid_d       : next valid bit, taken every cycle
//   load, pay_d   : payload load enable and value
//   valid_q, pay_q: registered entry
module pipe_entry_reg #(
    parameter int unsigned PAY_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_d,
    input  logic             load,
    input  logic [PAY_W-1:0] pay_d,
    output logic             valid_q,
    output logic [PAY_W-1:0] pay_q
);

    // Payload only moves on load so it holds through bubbles and flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                pay_q <= pay_d;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one-entry-latency pipeline register with a skid entry so
// in_ready is fully registered. Flush discards everything held; out_ctrl is
// forced to NOP_CTRL whenever no entry is presented; err flags an upstream
// offer withdrawn before it was accepted.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of pipe_stage_skid_if (in_*, out_*, flush, err)
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CTRL_W = 24,
    parameter logic [((CTRL_W > 0) ? CTRL_W : 1)-1:0] NOP_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stage_skid_if.slave  bus
);

    localparam int unsigned DATA_SW = nz_w(DATA_W);
    localparam int unsigned CTRL_SW = nz_w(CTRL_W);
    localparam int unsigned PAY_W   = CTRL_SW + DATA_SW;

    logic [CTRL_SW-1:0] in_ctrl_k;
    logic [DATA_SW-1:0] in_data_k;
    logic [PAY_W-1:0]   in_pay;
    logic [PAY_W-1:0]   main_pay_d;
    logic [PAY_W-1:0]   main_pay;
    logic [PAY_W-1:0]   skid_pay;
    logic               main_valid;
    logic               skid_valid;
    logic               in_fire;
    logic               main_free;
    logic               pend_q;
    logic               err_q;
    stage_ctrl_t        sc;

    // Zero-width fields are stored as constant zero.
    assign in_ctrl_k = (CTRL_W > 0) ? bus.in_ctrl : '0;
    assign in_data_k = (DATA_W > 0) ? bus.in_data : '0;
    assign in_pay    = {in_ctrl_k, in_data_k};

    // in_ready comes straight from the skid valid flop.
    assign in_fire   = bus.in_valid & ~skid_valid;
    assign main_free = ~main_valid | bus.out_ready;

    // Entry movement: flush dominates, then drain/refill of main, then skid capture.
    always_comb begin
        sc.main_valid     = main_valid;
        sc.main_load      = 1'b0;
        sc.main_from_skid = 1'b0;
        sc.skid_valid     = skid_valid;
        sc.skid_load      = 1'b0;
        if (bus.flush) begin
            sc.main_valid = 1'b0;
            sc.skid_valid = 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                // Older skid entry goes first; upstream is stalled this cycle.
                sc.main_valid     = 1'b1;
                sc.main_load      = 1'b1;
                sc.main_from_skid = 1'b1;
                sc.skid_valid     = 1'b0;
            end else if (in_fire) begin
                sc.main_valid = 1'b1;
                sc.main_load  = 1'b1;
            end else begin
                sc.main_valid = 1'b0;
            end
        end else if (in_fire) begin
            sc.skid_valid = 1'b1;
            sc.skid_load  = 1'b1;
        end
    end

    assign main_pay_d = sc.main_from_skid ? skid_pay : in_pay;

    pipe_entry_reg #(.PAY_W(PAY_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .valid_d (sc.main_valid),
        .load    (sc.main_load),
        .pay_d   (main_pay_d),
        .valid_q (main_valid),
        .pay_q   (main_pay)
    );

    pipe_entry_reg #(.PAY_W(PAY_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .valid_d (sc.skid_valid),
        .load    (sc.skid_load),
        .pay_d   (in_pay),
        .valid_q (skid_valid),
        .pay_q   (skid_pay)
    );

    // Sticky error: a stalled, unflushed offer disappears the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= bus.in_valid & skid_valid & ~bus.flush;
            if (pend_q & ~bus.in_valid & ~bus.flush) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = ~skid_valid;
    assign bus.out_valid = main_valid;
    assign bus.out_ctrl  = main_valid ? main_pay[PAY_W-1 -: CTRL_SW] : NOP_CTRL;
    assign bus.out_data  = main_pay[DATA_SW-1:0];
    assign bus.err       = err_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Table-driven bench for pipe_stage_skid: three width configurations share
// one stimulus stream; every vector's expected outputs are written by hand.
module tb_pipe_stage_skid;
    import pipe_stage_skid_pkg::*;

    typedef struct {
        logic        vin;
        logic [31:0] din;
        logic        ordy;
        logic        fl;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [23:0] in_ctrl;
    logic [31:0] in_data;
    logic        out_ready;
    logic        flush;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.DATA_W(16), .CTRL_W(24)) if0 ();
    pipe_stage_skid_if #(.DATA_W(32), .CTRL_W(1))  if1 ();
    pipe_stage_skid_if #(.DATA_W(1),  .CTRL_W(0))  if2 ();

    assign if0.in_valid  = in_valid;
    assign if0.in_ctrl   = in_ctrl;
    assign if0.in_data   = in_data[15:0];
    assign if0.out_ready = out_ready;
    assign if0.flush     = flush;

    assign if1.in_valid  = in_valid;
    assign if1.in_ctrl   = in_ctrl[0];
    assign if1.in_data   = in_data;
    assign if1.out_ready = out_ready;
    assign if1.flush     = flush;

    assign if2.in_valid  = in_valid;
    assign if2.in_ctrl   = 1'b0;
    assign if2.in_data   = in_data[0];
    assign if2.out_ready = out_ready;
    assign if2.flush     = flush;

    pipe_stage_skid #(.DATA_W(16), .CTRL_W(24), .NOP_CTRL(CTRL_NOP)) u_dut0 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    pipe_stage_skid #(.DATA_W(32), .CTRL_W(1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (if1)
    );
    pipe_stage_skid #(.DATA_W(1), .CTRL_W(0)) u_dut2 (
        .clk (clk), .rst (rst), .bus (if2)
    );

    // Control bits travel with the data so reordering shows up in ctrl too.
    function automatic logic [23:0] ctrl_of(input logic [31:0] d);
        return {8'hC3, d[15:0]};
    endfunction

    function automatic vec_t mk(input logic vin, input logic [31:0] din,
                                input logic ordy, input logic fl,
                                input logic e_rdy, input logic e_vld,
                                input logic [31:0] e_data, input logic e_err);
        vec_t v;
        v.vin = vin;   v.din = din;     v.ordy = ordy;   v.fl = fl;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_err = e_err;
        return v;
    endfunction

    task automatic cmp(input string tag, input string fld, input int cfg,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cfg%0d %s: got %h want %h", tag, cfg, fld, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_rdy, input logic e_vld,
                             input logic [31:0] e_data, input logic e_err);
        logic [23:0] e_ctrl;
        logic        a_rdy, a_vld, a_err;
        logic [23:0] a_ctrl, cmask;
        logic [31:0] a_data, dmask;
        e_ctrl = e_vld ? ctrl_of(e_data) : 24'(CTRL_NOP);
        for (int cfg = 0; cfg < 3; cfg++) begin
            case (cfg)
                0: begin
                    a_rdy = if0.in_ready; a_vld = if0.out_valid; a_err = if0.err;
                    a_ctrl = 24'(if0.out_ctrl); a_data = 32'(if0.out_data);
                    cmask = 24'hFFFFFF; dmask = 32'h0000FFFF;
                end
                1: begin
                    a_rdy = if1.in_ready; a_vld = if1.out_valid; a_err = if1.err;
                    a_ctrl = 24'(if1.out_ctrl); a_data = 32'(if1.out_data);
                    cmask = 24'h000001; dmask = 32'hFFFFFFFF;
                end
                default: begin
                    a_rdy = if2.in_ready; a_vld = if2.out_valid; a_err = if2.err;
                    a_ctrl = 24'(if2.out_ctrl); a_data = 32'(if2.out_data);
                    cmask = 24'h000000; dmask = 32'h00000001;
                end
            endcase
            cmp(tag, "in_ready",  cfg, 32'(a_rdy), 32'(e_rdy));
            cmp(tag, "out_valid", cfg, 32'(a_vld), 32'(e_vld));
            cmp(tag, "out_data",  cfg, a_data & dmask, e_data & dmask);
            cmp(tag, "err",       cfg, 32'(a_err), 32'(e_err));
            if (cmask != 24'h0) begin
                cmp(tag, "out_ctrl", cfg, 32'(a_ctrl & cmask), 32'(e_ctrl & cmask));
            end
        end
    endtask

    task automatic drive(input logic vin, input logic [31:0] din,
                         input logic ordy, input logic fl);
        in_valid  = vin;
        in_data   = din;
        in_ctrl   = ctrl_of(din);
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] a, b, c;
        a = 32'h1111_AAA1;
        b = 32'h2222_BBB0;
        c = 32'h3333_CCC1;

        // Streaming: one accepted per cycle, presented after the accepting edge.
        for (int i = 1; i <= 8; i++) begin
            vecs.push_back(mk(1, 32'hA5A5_0000 | 32'(i), 1, 0, 1, 1, 32'hA5A5_0000 | 32'(i), 0));
        end
        vecs.push_back(mk(0, 32'h0, 1, 0, 1, 0, 32'hA5A5_0008, 0));
        // Backpressure: A to main, B to skid, C stalled, then drain in order.
        vecs.push_back(mk(1, a, 0, 0, 1, 1, a, 0));
        vecs.push_back(mk(1, b, 0, 0, 0, 1, a, 0));
        vecs.push_back(mk(1, c, 0, 0, 0, 1, a, 0));
        vecs.push_back(mk(1, c, 1, 0, 1, 1, b, 0));
        vecs.push_back(mk(1, c, 1, 0, 1, 1, c, 0));
        vecs.push_back(mk(0, 32'h0, 1, 0, 1, 0, c, 0));
        // Flush with both entries full and a new offer present.
        vecs.push_back(mk(1, a, 0, 0, 1, 1, a, 0));
        vecs.push_back(mk(1, b, 0, 0, 0, 1, a, 0));
        vecs.push_back(mk(1, c, 0, 1, 1, 0, a, 0));
        vecs.push_back(mk(0, 32'h0, 1, 0, 1, 0, a, 0));
        // Flush beats a simultaneous drain and accept.
        vecs.push_back(mk(1, b, 1, 0, 1, 1, b, 0));
        vecs.push_back(mk(1, c, 1, 1, 1, 0, b, 0));
        vecs.push_back(mk(0, 32'h0, 1, 0, 1, 0, b, 0));
        // Protocol violation: stalled C withdrawn, err sticks.
        vecs.push_back(mk(1, a, 0, 0, 1, 1, a, 0));
        vecs.push_back(mk(1, b, 0, 0, 0, 1, a, 0));
        vecs.push_back(mk(1, c, 0, 0, 0, 1, a, 0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, a, 1));
        vecs.push_back(mk(0, 32'h0, 1, 0, 1, 1, b, 1));
        vecs.push_back(mk(0, 32'h0, 1, 0, 1, 0, b, 1));
        vecs.push_back(mk(0, 32'h0, 1, 0, 1, 0, b, 1));

        rst = 1'b1;
        drive(0, 32'h0, 0, 0);
        #1;
        check_all("reset", 1, 0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].vin, vecs[i].din, vecs[i].ordy, vecs[i].fl);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_vld,
                      vecs[i].e_data, vecs[i].e_err);
        end

        // Async reset mid-stream with main and skid full and err set.
        drive(1, a, 0, 0);
        @(posedge clk);
        #1 drive(1, b, 0, 0);
        @(posedge clk);
        #1 check_all("pre_rst", 0, 1, a, 1);
        rst = 1'b1;
        #1 check_all("async_rst", 1, 0, 32'h0, 0);
        drive(0, 32'h0, 1, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1, c, 1, 0);
        @(posedge clk);
        #1 check_all("post_rst", 1, 1, c, 0);
        drive(0, 32'h0, 1, 0);
        @(posedge clk);
        #1 check_all("post_rst_drain", 1, 0, c, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
